// File: rtl/nios2_vjtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_vjtag_pkg
//  Description : Shared types and constants for the Nios II virtual-JTAG
//                scan master: FSM state encoding, virtual IR codes and the
//                default data-register length.
//  Revision    : 1.0 - initial release
// ============================================================================
package nios2_vjtag_pkg;

    // Default data-register length shifted per scan
    localparam int DR_WIDTH_DEFAULT = 38;

    // Virtual IR codes understood by the debug module
    localparam logic [1:0] OCIMEM    = 2'b00;
    localparam logic [1:0] TRACEMEM  = 2'b01;
    localparam logic [1:0] BREAK     = 2'b10;
    localparam logic [1:0] TRACECTRL = 2'b11;

    // Scan sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RSP  = 3'd6
    } vjtag_state_t;

    // True for every state in which the virtual TCK is running
    function automatic logic is_scan_state(input vjtag_state_t s);
        return (s == ST_UIR) || (s == ST_CDR) || (s == ST_SDR) ||
               (s == ST_UDR) || (s == ST_RTI);
    endfunction

endpackage : nios2_vjtag_pkg
`default_nettype wire

// File: rtl/nios2_vjtag_tck_gen.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_vjtag_tck_gen
//  Description : Virtual TCK divider. One TCK period is 2*TCK_DIV clk cycles,
//                low for the first half and high for the second. All outputs
//                are registered and describe the current clk cycle.
//                i_scan_next tells the divider whether the coming cycle is
//                part of a scan, so the first scan cycle is already phase 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2_vjtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scan_next,
    output logic o_tck,
    output logic o_rise,
    output logic o_period_start,
    output logic o_period_last
);

    localparam int                 c_CNT_W = $clog2(2 * TCK_DIV);
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(TCK_DIV);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(2 * TCK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_run;
    logic [c_CNT_W-1:0] w_ph_next;

    // Phase of the coming cycle: restart at 0 when a scan begins, else wrap
    assign w_ph_next = !r_run          ? '0 :
                       (r_cnt == c_LAST) ? '0 : (r_cnt + c_ONE);

    // Phase counter and registered TCK/strobe outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_run          <= 1'b0;
            o_tck          <= 1'b0;
            o_rise         <= 1'b0;
            o_period_start <= 1'b0;
            o_period_last  <= 1'b0;
        end else if (!i_scan_next) begin
            r_cnt          <= '0;
            r_run          <= 1'b0;
            o_tck          <= 1'b0;
            o_rise         <= 1'b0;
            o_period_start <= 1'b0;
            o_period_last  <= 1'b0;
        end else begin
            r_cnt          <= w_ph_next;
            r_run          <= 1'b1;
            o_tck          <= (w_ph_next >= c_HALF);
            o_rise         <= (w_ph_next == c_HALF);
            o_period_start <= (w_ph_next == '0);
            o_period_last  <= (w_ph_next == c_LAST);
        end
    end

endmodule : nios2_vjtag_tck_gen
`default_nettype wire

// File: rtl/nios2_vjtag_scan_master.sv
`default_nettype none
// ============================================================================
//  Module      : nios2_vjtag_scan_master
//  Description : Drives one virtual-JTAG scan per accepted command:
//                UIR -> CDR -> SDR (DR_WIDTH bits) -> UDR -> RTI, then offers
//                the captured TDO word on a valid/ready response port.
//                Data is shifted LSB first; captured bit k lands in bit k.
//  Options     : NIOS2_VJTAG_IR_CACHE_EN - when defined, UIR is skipped if the
//                requested IR equals the IR of the last completed UIR.
//  Revision    : 1.0 - initial release
// ============================================================================
module nios2_vjtag_scan_master
    import nios2_vjtag_pkg::*;
#(
    parameter int TCK_DIV  = 2,
    parameter int DR_WIDTH = DR_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int                 c_BIT_W    = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DR_WIDTH - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);

    vjtag_state_t          r_state;
    vjtag_state_t          w_state_next;
    logic                  w_accept;
    logic                  w_ir_hit;
    logic                  w_tdi_next;
    logic                  w_rise;
    logic                  w_period_start;
    logic                  w_period_last;
    logic [c_BIT_W-1:0]    r_bit;
    logic [DR_WIDTH-1:0]   r_dr;
    logic [DR_WIDTH-1:0]   w_dr_shift;

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_dr_shift = r_dr >> 1;

`ifdef NIOS2_VJTAG_IR_CACHE_EN
    logic r_ir_cache_valid;

    // vji_ir_in always holds the IR of the most recent UIR, so it doubles as
    // the cache tag; only the valid bit needs its own register.
    assign w_ir_hit = r_ir_cache_valid && (cmd_ir == vji_ir_in);

    // Cache becomes valid once a UIR period has fully completed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_cache_valid <= 1'b0;
        end else if ((r_state == ST_UIR) && w_period_last) begin
            r_ir_cache_valid <= 1'b1;
        end
    end
`else
    assign w_ir_hit = 1'b0;
`endif

    // TCK divider; it looks at the next state so phase 0 lines up with entry
    nios2_vjtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk            (clk),
        .rst            (reset),
        .i_scan_next    (is_scan_state(w_state_next)),
        .o_tck          (vji_tck),
        .o_rise         (w_rise),
        .o_period_start (w_period_start),
        .o_period_last  (w_period_last)
    );

    // Next-state decode: every scan state advances on the last cycle of a TCK period
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)      w_state_next = w_ir_hit ? ST_CDR : ST_UIR;
            ST_UIR:  if (w_period_last) w_state_next = ST_CDR;
            ST_CDR:  if (w_period_last) w_state_next = ST_SDR;
            ST_SDR:  if (w_period_last && (r_bit == c_LAST_BIT)) w_state_next = ST_UDR;
            ST_UDR:  if (w_period_last) w_state_next = ST_RTI;
            ST_RTI:  if (w_period_last) w_state_next = ST_RSP;
            ST_RSP:  if (rsp_ready)     w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // TDI for the coming cycle: bit k is presented from the first cycle of SDR period k
    always_comb begin
        w_tdi_next = 1'b0;
        if (w_state_next == ST_SDR) begin
            if ((r_state == ST_SDR) && w_period_last) begin
                w_tdi_next = w_dr_shift[0];
            end else begin
                w_tdi_next = r_dr[0];
            end
        end
    end

    // Scan sequencer: state, registered flags, shift/capture datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            vji_tdi   <= 1'b0;
            vji_ir_in <= 2'b00;
            vji_uir   <= 1'b0;
            vji_cdr   <= 1'b0;
            vji_sdr   <= 1'b0;
            vji_udr   <= 1'b0;
            vji_rti   <= 1'b0;
            r_bit     <= '0;
            r_dr      <= '0;
        end else begin
            r_state   <= w_state_next;
            cmd_ready <= (w_state_next == ST_IDLE);
            rsp_valid <= (w_state_next == ST_RSP);
            vji_uir   <= (w_state_next == ST_UIR);
            vji_cdr   <= (w_state_next == ST_CDR);
            vji_sdr   <= (w_state_next == ST_SDR);
            vji_udr   <= (w_state_next == ST_UDR);
            vji_rti   <= (w_state_next == ST_RTI);
            vji_tdi   <= w_tdi_next;

            if (w_accept) begin
                r_dr <= cmd_data;
                if (!w_ir_hit) begin
                    vji_ir_in <= cmd_ir;
                end
            end

            // Bit index is re-armed during CDR, before the first shift period
            if ((r_state == ST_CDR) && w_period_start) begin
                r_bit <= '0;
            end

            // TDO is sampled in the cycle where TCK rises
            if ((r_state == ST_SDR) && w_rise) begin
                rsp_data[r_bit] <= vji_tdo;
            end

            if ((r_state == ST_SDR) && w_period_last) begin
                r_bit <= r_bit + c_BIT_ONE;
                r_dr  <= w_dr_shift;
            end
        end
    end

endmodule : nios2_vjtag_scan_master
`default_nettype wire

// File: doc/nios2_vjtag_scan_master.md
NIOS2_VJTAG_SCAN_MASTER -- requirements
Module: nios2_vjtag_scan_master

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning clk cycles per vji_tck half-period (legal 1..255).
REQ-002 SHALL have parameter DR_WIDTH, default 38, meaning data-register length in bits shifted per scan.
REQ-003 SHALL have port clk  in  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_ir in 2, cmd_data in DR_WIDTH  scan request: virtual IR value plus DR word, LSB shifted first.
REQ-006 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out DR_WIDTH  captured vji_tdo word, first-captured bit in bit 0.
REQ-007 SHALL have ports vji_tck out 1, vji_tdi out 1, vji_tdo in 1, vji_ir_in out 2  virtual JTAG clock, data and IR toward the debug module's tck-domain logic.
REQ-008 SHALL have ports vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti out 1 each  virtual state flags.

Function
REQ-009 SHALL run the FSM IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RSP -> IDLE, with UIR, CDR, UDR and RTI each lasting exactly one tck period.
REQ-010 SHALL set one tck period to 2*TCK_DIV clk cycles: vji_tck low for the first TCK_DIV cycles and high for the last TCK_DIV cycles; vji_tck SHALL be held low in IDLE and RSP.
REQ-011 SHALL assert cmd_ready only in IDLE and accept a command on the clk edge where cmd_valid && cmd_ready, latching cmd_ir and cmd_data.
REQ-012 SHALL drive vji_ir_in with the latched IR from the first UIR cycle onward and hold it until the next accepted command's UIR.
REQ-013 SHALL assert each of vji_uir, vji_cdr, vji_sdr, vji_udr and vji_rti for exactly its own state's duration; at most one flag is high in any cycle.
REQ-014 SHALL stay in SDR for exactly DR_WIDTH tck periods, present data bit k on vji_tdi at the start of period k (tck low), and keep vji_tdi at 0 outside SDR.
REQ-015 SHALL sample vji_tdo on the clk cycle in which vji_tck rises in SDR period k and store the sample in rsp_data bit k.
REQ-016 SHALL raise rsp_valid (RSP state) on the cycle after RTI ends: (DR_WIDTH+4)*2*TCK_DIV+1 clk cycles after the accept edge, which is 169 cycles at the default parameter values.
REQ-017 SHALL hold rsp_valid and rsp_data stable until the rsp_valid && rsp_ready edge, then return to IDLE, with cmd_ready high on the next cycle.
REQ-018 SHALL ignore cmd_valid whenever the FSM is not in IDLE; no command queueing.

Reset
REQ-019 SHALL, on any clk edge with reset high, including mid-scan, enter IDLE and abandon the scan with no response.
REQ-020 SHALL set these reset values on that edge: cmd_ready=1; rsp_valid=0; rsp_data=0; vji_tck, vji_tdi, all state flags and vji_ir_in = 0; tck divider count = 0; IR cache invalid.

Configuration
REQ-021 SHALL, when NIOS2_VJTAG_IR_CACHE_EN is defined, skip UIR (CDR directly after accept) when cmd_ir equals the IR of the last completed UIR and the cache is valid, making latency (DR_WIDTH+3)*2*TCK_DIV+1 cycles.
REQ-022 SHALL, when NIOS2_VJTAG_IR_CACHE_EN is undefined, always execute UIR and contain no IR-cache register.

Structure
REQ-023 SHALL take from a shared package nios2_vjtag_pkg the FSM state enum, the IR code constants (OCIMEM=2'b00, TRACEMEM=2'b01, BREAK=2'b10, TRACECTRL=2'b11) and DR_WIDTH_DEFAULT=38.
REQ-024 SHALL place the tck divider in one sub-module, nios2_vjtag_tck_gen, which outputs vji_tck, a one-cycle rise strobe and a one-cycle period-start strobe.

Verification
REQ-025 SHALL cover: default parameters, cmd_ir=2'b10 and cmd_data=38'h2A_5A5A_5A5A with vji_tdo looped to vji_tdi -> rsp_valid at cycle 169 and rsp_data=38'h2A_5A5A_5A5A.
REQ-026 SHALL cover: vji_tdo tied to 1 and cmd_data=0 -> rsp_data=38'h3F_FFFF_FFFF, vji_tdi=0 throughout, and exactly 38 vji_tck rising edges while vji_sdr=1.
REQ-027 SHALL cover: rsp_ready held low for 50 cycles after rsp_valid -> rsp_valid and rsp_data stable and cmd_ready low for all 50 cycles; a cmd_valid pulse during that window is dropped.
REQ-028 SHALL cover: reset pulsed for one cycle during SDR bit 20 -> next cycle all outputs at reset values, cmd_ready=1, and no rsp_valid afterwards.
REQ-029 SHALL cover: with NIOS2_VJTAG_IR_CACHE_EN defined, two scans with cmd_ir=2'b01 -> the second scan has no vji_uir pulse and rsp_valid 4 cycles earlier (165); a third scan with cmd_ir=2'b00 pulses vji_uir.
REQ-030 SHALL cover: TCK_DIV=1 with cmd_data=38'h1 -> vji_tck toggles every clk cycle, vji_tdi=1 only in SDR period 0, and rsp_valid at cycle 85.
